// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size codes, FSM states,
// byte-lane mask and alignment check.
package lsu_pkg;

  localparam int unsigned INDEX_BITS_DEF = 8;
  localparam int unsigned DATA_W         = 64;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Byte lanes of a doubleword touched by an access of this size at this offset
  function automatic logic [7:0] byte_mask(size_e size, logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      SIZE_W:  base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  function automatic logic misaligned(size_e size, logic [2:0] offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      SIZE_W:  return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges store data
// into the doubleword read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e              size_i,
  input  logic               signed_i,
  input  logic [2:0]         offset_i,
  input  logic [DATA_W-1:0]  rdata_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  load_data_c,
  output logic [DATA_W-1:0]  merged_c
);

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] bit_mask;
  logic [7:0]        bmask;

  always_comb begin
    lane        = rdata_i >> {offset_i, 3'b000};
    wshift      = wdata_i << {offset_i, 3'b000};
    bmask       = byte_mask(size_i, offset_i);
    bit_mask    = '0;
    load_data_c = lane;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{bmask[i]}};
    end
    merged_c = (rdata_i & ~bit_mask) | (wshift & bit_mask);
    case (size_i)
      SIZE_B:  load_data_c = {{56{signed_i & lane[7]}},  lane[7:0]};
      SIZE_H:  load_data_c = {{48{signed_i & lane[15]}}, lane[15:0]};
      SIZE_W:  load_data_c = {{32{signed_i & lane[31]}}, lane[31:0]};
      default: load_data_c = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store controller for the 64-bit data memory: handshake with the core,
// alignment checking, read-modify-write for narrow stores, extended loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_misaligned,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_W-1:0]     mem_write_data,
  input  logic [DATA_W-1:0]     mem_read_data
);

  localparam int unsigned AW_USED = INDEX_BITS + 3;
  localparam int unsigned MA_W    = INDEX_BITS + 2;

  state_e              state_q, state_d;
  logic                write_q, signed_q, mis_q;
  size_e               size_q;
  logic [AW_USED-1:0]  addr_q;
  logic [DATA_W-1:0]   merged_q, rdata_q;

  size_e               req_size_e;
  logic                req_fault;
  logic                accept;
  logic [DATA_W-1:0]   load_data_c, merged_c;
  logic                unused_addr_hi;

  assign req_size_e     = size_e'(req_size);
  assign req_fault      = misaligned(req_size_e, req_addr[2:0]);
  assign accept         = req_valid && (state_q == IDLE);
  assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:AW_USED];

  lsu_align u_align (
    .size_i      (size_q),
    .signed_i    (signed_q),
    .offset_i    (addr_q[2:0]),
    .rdata_i     (mem_read_data),
    .wdata_i     (merged_q),
    .load_data_c (load_data_c),
    .merged_c    (merged_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Strobes are pure state decodes so reset removes mem_write asynchronously
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault)                             state_d = RESP;
          else if (req_write && req_size_e == SIZE_D) state_d = WRITE;
          else                                       state_d = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        state_d  = write_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // merged_q holds the raw store data until READ replaces it with the merged doubleword
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      mis_q    <= 1'b0;
      size_q   <= SIZE_B;
      addr_q   <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      write_q  <= req_write;
      signed_q <= req_signed;
      mis_q    <= req_fault;
      size_q   <= req_size_e;
      addr_q   <= req_addr[AW_USED-1:0];
      merged_q <= req_wdata;
      rdata_q  <= '0;
    end else if (state_q == READ) begin
      if (write_q) merged_q <= merged_c;
      else         rdata_q  <= load_data_c;
    end
  end

  assign mem_address     = ADDR_WIDTH'({addr_q[AW_USED-1:3], 2'b00});
  assign mem_write_data  = mem_write ? merged_q : '0;
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = resp_valid & mis_q;

  logic unused_width_chk;
  assign unused_width_chk = (MA_W <= ADDR_WIDTH);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory and request
// queue predict every response and memory access, plus literal expectations.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [63:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  load_store_unit #(.ADDR_WIDTH(64), .INDEX_BITS(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  // Data memory attached to the DUT
  logic [63:0] dmem [0:255];
  assign mem_read_data = mem_read ? dmem[mem_address[9:2]] : 64'h0;
  always @(posedge clock) if (mem_write) dmem[mem_address[9:2]] <= mem_write_data;

  // Reference model: flat byte memory and outstanding request queue
  logic [7:0] rmem [0:2047];
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] a;
    logic [63:0] d;
    int          due;
  } req_t;
  req_t q[$];

  int checks = 0, errors = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, acc_cnt = 0;
  logic [63:0] last_rdata = '0, prev_rdata = '0, last_wr_addr = '0, last_wr_data = '0;
  logic        last_mis = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_mis(logic [63:0] a, logic [1:0] sz);
    int n = 1 << sz;
    return (int'(a[2:0]) % n) != 0;
  endfunction

  function automatic logic [63:0] m_load(logic [63:0] a, logic [1:0] sz, logic sg);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = rmem[a[10:0] + 11'(i)];
    if (sg && sz != 2'd3 && v[n*8-1]) for (int i = n*8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] m_merge(req_t r);
    int n = 1 << r.sz;
    int off = int'(r.a[2:0]);
    logic [63:0] v = m_load({r.a[63:3], 3'b000}, 2'd3, 1'b0);
    for (int i = 0; i < n; i++) v[(off+i)*8 +: 8] = r.d[i*8 +: 8];
    return v;
  endfunction

  task automatic m_store(req_t r);
    int n = 1 << r.sz;
    for (int i = 0; i < n; i++) rmem[r.a[10:0] + 11'(i)] = r.d[i*8 +: 8];
  endtask

  // Per-cycle compare against the model
  always @(negedge clock) begin
    req_t r;
    logic [63:0] exp;
    logic mis;
    int lat;
    if (!reset_n) begin
      q.delete();
    end else begin
      chk("req_ready", 64'(req_ready), 64'(q.size() == 0));
      chk("rd_wr_exclusive", 64'(mem_read & mem_write), 64'h0);
      if (mem_read || mem_write) begin
        chk("access_while_busy", 64'(q.size() != 0), 64'h1);
        if (q.size() != 0) begin
          chk("access_on_fault", 64'(m_mis(q[0].a, q[0].sz)), 64'h0);
          chk("mem_address", mem_address, {q[0].a[63:3], 2'b00} & 64'h3FC);
          if (mem_write) chk("mem_write_data", mem_write_data, m_merge(q[0]));
        end
        if (mem_read) rd_cnt++;
        if (mem_write) begin
          wr_cnt++;
          last_wr_addr = mem_address;
          last_wr_data = mem_write_data;
        end
      end
      if (resp_valid) begin
        chk("resp_expected", 64'(q.size() != 0), 64'h1);
        if (q.size() != 0) begin
          r = q.pop_front();
          chk("resp_latency", 64'(cyc), 64'(r.due));
          mis = m_mis(r.a, r.sz);
          exp = (mis || r.w) ? 64'h0 : m_load(r.a, r.sz, r.sg);
          chk("resp_misaligned", 64'(resp_misaligned), 64'(mis));
          chk("resp_rdata", resp_rdata, exp);
          if (r.w && !mis) m_store(r);
          prev_rdata = last_rdata;
          last_rdata = resp_rdata;
          last_mis   = resp_misaligned;
        end
      end else if (q.size() != 0 && cyc >= q[0].due) begin
        chk("resp_missing", 64'(resp_valid), 64'h1);
        void'(q.pop_front());
      end
      if (req_valid && req_ready) begin
        r.w = req_write; r.sz = req_size; r.sg = req_signed;
        r.a = req_addr;  r.d = req_wdata;
        lat = m_mis(req_addr, req_size) ? 1 : ((!req_write || req_size == 2'd3) ? 2 : 3);
        r.due = cyc + lat;
        q.push_back(r);
        acc_cnt++;
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] d);
    bit got = 0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (req_ready) got = 1;
    end
    if (!got) chk("accept_timeout", 64'(req_ready), 64'h1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock); #1;
      if (q.size() == 0 && req_ready) done = 1;
    end
    if (!done) chk("idle_timeout", {62'h0, req_ready, q.size() == 0}, 64'h3);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sg, input logic [63:0] a,
                    input string name, input logic [63:0] exp);
    do_req(1'b0, sz, sg, a, 64'h0);
    wait_idle();
    chk(name, last_rdata, exp);
  endtask

  initial begin
    int w0, r0, a0;
    bit seen;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_signed = 1'b0;
    req_addr = 64'h18; req_wdata = 64'hDEAD;
    for (int i = 0; i < 256; i++) dmem[i] = 64'h0;
    for (int i = 0; i < 2048; i++) rmem[i] = 8'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_mem_rw", {62'h0, mem_read, mem_write}, 64'h0);
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_mem_address", mem_address, 64'h0);
    chk("rst_mem_wdata", mem_write_data, 64'h0);
    req_valid = 1'b0;
    @(negedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    chk("rst_no_write_commit", dmem[3], 64'h0);

    w0 = wr_cnt; r0 = rd_cnt;
    do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h0123456789ABCDEF);
    wait_idle();
    chk("st_d_wr_cycles", 64'(wr_cnt - w0), 64'h1);
    chk("st_d_rd_cycles", 64'(rd_cnt - r0), 64'h0);
    chk("st_d_addr", last_wr_addr, 64'h0C);
    ld(2'd3, 1'b0, 64'h18, "ld_d_18", 64'h0123456789ABCDEF);
    ld(2'd0, 1'b0, 64'h1F, "ld_bu_1f", 64'h01);
    ld(2'd0, 1'b1, 64'h18, "ld_bs_18", 64'hFFFFFFFFFFFFFFEF);
    ld(2'd0, 1'b0, 64'h18, "ld_bu_18", 64'hEF);

    w0 = wr_cnt; r0 = rd_cnt;
    do_req(1'b1, 2'd1, 1'b0, 64'h1A, 64'h000000000000BEEF);
    wait_idle();
    chk("st_h_rd_cycles", 64'(rd_cnt - r0), 64'h1);
    chk("st_h_wr_cycles", 64'(wr_cnt - w0), 64'h1);
    chk("st_h_wdata", last_wr_data, 64'h01234567BEEFCDEF);
    ld(2'd3, 1'b0, 64'h18, "ld_d_after_h", 64'h01234567BEEFCDEF);
    ld(2'd1, 1'b1, 64'h1A, "ld_hs_1a", 64'hFFFFFFFFFFFFBEEF);
    ld(2'd2, 1'b1, 64'h1C, "ld_ws_1c", 64'h0000000001234567);

    w0 = wr_cnt; r0 = rd_cnt;
    do_req(1'b0, 2'd2, 1'b0, 64'h1A, 64'h0);
    wait_idle();
    chk("fault_mis", 64'(last_mis), 64'h1);
    chk("fault_rdata", last_rdata, 64'h0);
    chk("fault_no_access", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'h0);

    // req_valid held through a busy store, then a load queued behind it
    a0 = acc_cnt;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_signed = 1'b0;
    req_addr = 64'h10; req_wdata = 64'hFEDCBA9876543210;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clock); if (req_ready) seen = 1; end
    @(posedge clock); #1;
    req_write = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clock); if (req_ready) seen = 1; end
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("busy_accepts", 64'(acc_cnt - a0), 64'h2);
    do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'h0);
    wait_idle();
    chk("b2b_ld_10", prev_rdata, 64'hFEDCBA9876543210);
    chk("b2b_ld_18", last_rdata, 64'h01234567BEEFCDEF);

    // Reset during the WRITE of a half store
    do_req(1'b1, 2'd1, 1'b0, 64'h18, 64'h0000000000005555);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(posedge clock); #1; if (mem_write) seen = 1; end
    chk("rst_saw_write", 64'(seen), 64'h1);
    #2 reset_n = 1'b0;
    #1 chk("rst_mem_write_drop", 64'(mem_write), 64'h0);
    chk("rst_mid_ready", 64'(req_ready), 64'h1);
    @(negedge clock); #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    ld(2'd3, 1'b0, 64'h18, "rst_ld_18", 64'h01234567BEEFCDEF);
    chk("dmem_18", dmem[3], 64'h01234567BEEFCDEF);
    chk("dmem_10", dmem[2], 64'hFEDCBA9876543210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
